// File: rtl/cdb_arbiter_pkg.sv
// Shared pipeline definitions for the common data bus: unit indices, default
// widths and the broadcast record used by writeback and the issue queues.
package cdb_arbiter_pkg;

    localparam int unsigned FU_INTALU   = 0;
    localparam int unsigned FU_FPALU    = 1;
    localparam int unsigned FU_AGU      = 2;
    localparam int unsigned N_FU        = 3;

    localparam int unsigned CDB_TAG_W  = 6;
    localparam int unsigned CDB_DATA_W = 32;
    localparam int unsigned CDB_SRC_W  = 2;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
        logic                  exc;
        logic [CDB_SRC_W-1:0]  src;
    } cdb_bus_t;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from rr_ptr with wrap,
// pointer advances past the winner on each accepted grant.
module rr_arbiter #(
    parameter int unsigned N_REQ = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    input  logic             adv,
    output logic [N_REQ-1:0] gnt
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(N_REQ - 1);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win_idx;
    logic             found;
    int unsigned      idx;

    always_comb begin
        gnt     = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (en && !found && req[PTR_W'(idx)]) begin
                gnt[PTR_W'(idx)] = 1'b1;
                win_idx          = PTR_W'(idx);
                found            = 1'b1;
            end
        end
    end

    // Explicit compare against the last index keeps the wrap correct for non-power-of-2 N_REQ.
    always_comb begin
        ptr_d = ptr_q;
        if (adv) ptr_d = (win_idx == LAST) ? '0 : win_idx + PTR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants one functional-unit result per cycle and drives the
// registered broadcast, with writeback stall and pipeline flush gating.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SRC_W  = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*TAG_W-1:0]  req_tag,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_exc,
    input  logic                    cdb_stall,
    input  logic                    flush,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [DATA_W-1:0]       cdb_data,
    output logic                    cdb_exc,
    output logic [SRC_W-1:0]        cdb_src
);

    logic              grant_en;
    logic              xfer;
    logic [N_REQ-1:0]  gnt;

    logic              valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              exc_q, exc_d;
    logic [SRC_W-1:0]  src_q, src_d;

    // resetn is active-high despite its name; it also masks grants while held.
    assign grant_en  = !resetn && !flush && !cdb_stall;
    assign req_ready = gnt;
    assign xfer      = |(req_valid & gnt);

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .clk (clk),
        .rst (resetn),
        .req (req_valid),
        .en  (grant_en),
        .adv (xfer),
        .gnt (gnt)
    );

    always_comb begin
        valid_d = xfer;
        tag_d   = tag_q;
        data_d  = data_q;
        exc_d   = exc_q;
        src_d   = src_q;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i] && req_valid[i]) begin
                tag_d  = req_tag[i*TAG_W +: TAG_W];
                data_d = req_data[i*DATA_W +: DATA_W];
                exc_d  = req_exc[i];
                src_d  = SRC_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
            exc_q   <= 1'b0;
            src_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            exc_q   <= exc_d;
            src_q   <= src_d;
        end
    end

    assign cdb_valid = valid_q;
    assign cdb_tag   = tag_q;
    assign cdb_data  = data_q;
    assign cdb_exc   = exc_q;
    assign cdb_src   = src_q;

endmodule
